// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: captures a multi-hot vector and emits the index of
// every set bit, highest first, over a valid/ready handshake.
module encoder_8x3_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] d,
  input  logic       d_valid,
  output logic       d_ready,
  output logic [2:0] I,
  output logic       I_valid,
  input  logic       I_ready,
  output logic       I_last,
  output logic [3:0] cnt,
  output logic       zero_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg, state_next;
  logic [7:0] pend_reg, pend_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       zero_err_reg, zero_err_next;

  logic [7:0] above;
  logic [7:0] top_bit;
  logic [2:0] idx;
  logic       single;
  logic       in_fire;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int k = 0; k < 8; k++) begin
      s = s + {3'b000, v[k]};
    end
    return s;
  endfunction

  // top_bit isolates the highest set bit of pend; it is also the clear mask on drain.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_prio
      if (gi == 7) begin : g_top
        assign above[gi] = 1'b0;
      end else begin : g_rest
        assign above[gi] = |pend_reg[7:gi+1];
      end
      assign top_bit[gi] = pend_reg[gi] & ~above[gi];
    end
  endgenerate

  always_comb begin
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (top_bit[k]) idx = 3'(k);
    end
  end

  assign single  = (pend_reg != 8'd0) && ((pend_reg & (pend_reg - 8'd1)) == 8'd0);
  assign d_ready = (state_reg == IDLE) && en && rst_n;
  assign in_fire = d_valid && d_ready;

  always_comb begin
    state_next    = state_reg;
    pend_next     = pend_reg;
    cnt_next      = cnt_reg;
    zero_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_fire) begin
          cnt_next = popcount(d);
          if (d != 8'd0) begin
            pend_next  = d;
            state_next = BUSY;
          end else begin
            zero_err_next = 1'b1;
          end
        end
      end
      BUSY: begin
        // en is deliberately ignored here so a drain always runs to completion.
        if (I_ready) begin
          pend_next = pend_reg & ~top_bit;
          if (single) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pend_reg     <= 8'd0;
      cnt_reg      <= 4'd0;
      zero_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pend_reg     <= pend_next;
      cnt_reg      <= cnt_next;
      zero_err_reg <= zero_err_next;
    end
  end

  assign I        = idx;
  assign I_valid  = (state_reg == BUSY);
  assign I_last   = (state_reg == BUSY) && single;
  assign cnt      = cnt_reg;
  assign zero_err = zero_err_reg;

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Directed bench for encoder_8x3_seq: each task drives one scenario and checks
// hand-computed expectations one cycle at a time.
module tb_encoder_8x3_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] d;
  logic       d_valid;
  logic       d_ready;
  logic [2:0] I;
  logic       I_valid;
  logic       I_ready;
  logic       I_last;
  logic [3:0] cnt;
  logic       zero_err;

  int errors = 0;
  int checks = 0;

  encoder_8x3_seq dut (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .I(I), .I_valid(I_valid), .I_ready(I_ready), .I_last(I_last), .cnt(cnt),
    .zero_err(zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; d = 8'hFF; d_valid = 1'b1; I_ready = 1'b1;
    #1;
    step();
    checks++; if (d_ready !== 1'b0)  begin errors++; $display("FAIL reset_d_ready got=%b exp=0", d_ready); end
    checks++; if (I_valid !== 1'b0)  begin errors++; $display("FAIL reset_I_valid got=%b exp=0", I_valid); end
    checks++; if (I !== 3'd0)        begin errors++; $display("FAIL reset_I got=%0d exp=0", I); end
    checks++; if (I_last !== 1'b0)   begin errors++; $display("FAIL reset_I_last got=%b exp=0", I_last); end
    checks++; if (cnt !== 4'd0)      begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++; if (zero_err !== 1'b0) begin errors++; $display("FAIL reset_zero_err got=%b exp=0", zero_err); end
    $display("reset: d_ready=%b I_valid=%b cnt=%0d", d_ready, I_valid, cnt);
  endtask

  task automatic test_first_capture();
    d = 8'h81; d_valid = 1'b1;
    rst_n = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL first_d_ready got=%b exp=1", d_ready); end
    step();
    d_valid = 1'b0;
    checks++; if (I_valid !== 1'b1 || I !== 3'd7) begin errors++; $display("FAIL first_cap got v=%b I=%0d exp v=1 I=7", I_valid, I); end
    checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL first_cnt got=%0d exp=2", cnt); end
    $display("first capture: I=%0d cnt=%0d", I, cnt);
    step();
    checks++; if (I !== 3'd0 || I_last !== 1'b1) begin errors++; $display("FAIL first_last got I=%0d last=%b exp I=0 last=1", I, I_last); end
    step();
    checks++; if (I_valid !== 1'b0) begin errors++; $display("FAIL first_done got=%b exp=0", I_valid); end
  endtask

  task automatic test_single();
    en = 1'b1; d = 8'b0000_0100; d_valid = 1'b1; I_ready = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL single_d_ready got=%b exp=1", d_ready); end
    step();
    d_valid = 1'b0;
    checks++; if (I_valid !== 1'b1 || I !== 3'd2 || I_last !== 1'b1) begin
      errors++; $display("FAIL single_out got v=%b I=%0d last=%b exp v=1 I=2 last=1", I_valid, I, I_last); end
    checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", cnt); end
    $display("single: I=%0d last=%b cnt=%0d", I, I_last, cnt);
    step();
    checks++; if (I_valid !== 1'b0 || d_ready !== 1'b1) begin
      errors++; $display("FAIL single_after got v=%b rdy=%b exp v=0 rdy=1", I_valid, d_ready); end
    checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL single_cnt_hold got=%0d exp=1", cnt); end
  endtask

  task automatic test_multi();
    int exp_idx[3] = '{7, 5, 0};
    d = 8'b1010_0001; d_valid = 1'b1; I_ready = 1'b1;
    step();
    d_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (I_valid !== 1'b1 || I !== 3'(exp_idx[i]) || I_last !== (i == 2)) begin
        errors++; $display("FAIL multi_out[%0d] got v=%b I=%0d last=%b exp v=1 I=%0d last=%b",
                           i, I_valid, I, I_last, exp_idx[i], (i == 2)); end
      $display("multi: I=%0d last=%b", I, I_last);
      step();
    end
    checks++; if (I_valid !== 1'b0) begin errors++; $display("FAIL multi_done got=%b exp=0", I_valid); end
    checks++; if (cnt !== 4'd3) begin errors++; $display("FAIL multi_cnt got=%0d exp=3", cnt); end
  endtask

  task automatic test_backpressure();
    d = 8'b0000_0110; d_valid = 1'b1; I_ready = 1'b0;
    step();
    d_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (I_valid !== 1'b1 || I !== 3'd2 || I_last !== 1'b0 || d_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b I=%0d last=%b rdy=%b exp v=1 I=2 last=0 rdy=0",
                           i, I_valid, I, I_last, d_ready); end
      step();
    end
    I_ready = 1'b1;
    #1;
    checks++; if (I !== 3'd2) begin errors++; $display("FAIL bp_first got=%0d exp=2", I); end
    $display("backpressure: I=%0d", I);
    step();
    checks++; if (I !== 3'd1 || I_last !== 1'b1) begin errors++; $display("FAIL bp_second got I=%0d last=%b exp I=1 last=1", I, I_last); end
    $display("backpressure: I=%0d last=%b", I, I_last);
    step();
    checks++; if (I_valid !== 1'b0) begin errors++; $display("FAIL bp_done got=%b exp=0", I_valid); end
  endtask

  task automatic test_zero();
    d = 8'h00; d_valid = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_pre got=%b exp=1", d_ready); end
    step();
    d_valid = 1'b0;
    checks++; if (zero_err !== 1'b1) begin errors++; $display("FAIL zero_err_pulse got=%b exp=1", zero_err); end
    checks++; if (I_valid !== 1'b0 || cnt !== 4'd0 || d_ready !== 1'b1) begin
      errors++; $display("FAIL zero_state got v=%b cnt=%0d rdy=%b exp v=0 cnt=0 rdy=1", I_valid, cnt, d_ready); end
    $display("zero: zero_err=%b cnt=%0d", zero_err, cnt);
    step();
    checks++; if (zero_err !== 1'b0 || I_valid !== 1'b0) begin
      errors++; $display("FAIL zero_after got err=%b v=%b exp err=0 v=0", zero_err, I_valid); end
  endtask

  task automatic test_full_enable();
    en = 1'b1; d = 8'hFF; d_valid = 1'b1; I_ready = 1'b1;
    step();
    d_valid = 1'b0; en = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      checks++; if (I_valid !== 1'b1 || I !== 3'(k) || I_last !== (k == 0)) begin
        errors++; $display("FAIL full_out[%0d] got v=%b I=%0d last=%b", k, I_valid, I, I_last); end
      $display("full: I=%0d last=%b", I, I_last);
      step();
    end
    checks++; if (I_valid !== 1'b0 || d_ready !== 1'b0) begin
      errors++; $display("FAIL full_after got v=%b rdy=%b exp v=0 rdy=0", I_valid, d_ready); end
    checks++; if (cnt !== 4'd8) begin errors++; $display("FAIL full_cnt got=%0d exp=8", cnt); end
    step();
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL full_en_low got=%b exp=0", d_ready); end
    en = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL full_en_high got=%b exp=1", d_ready); end
  endtask

  task automatic test_reset_mid_drain();
    d = 8'hF0; d_valid = 1'b1; I_ready = 1'b1;
    step();
    d_valid = 1'b0;
    checks++; if (I !== 3'd7) begin errors++; $display("FAIL rmd_first got=%0d exp=7", I); end
    step();
    checks++; if (I !== 3'd6 || I_valid !== 1'b1) begin errors++; $display("FAIL rmd_second got I=%0d v=%b exp I=6 v=1", I, I_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (I_valid !== 1'b0 || I !== 3'd0 || I_last !== 1'b0 || d_ready !== 1'b0 || cnt !== 4'd0) begin
      errors++; $display("FAIL rmd_async got v=%b I=%0d last=%b rdy=%b cnt=%0d exp all 0",
                         I_valid, I, I_last, d_ready, cnt); end
    $display("reset mid-drain: I_valid=%b I=%0d", I_valid, I);
    step();
    rst_n = 1'b1;
    step();
    checks++; if (I_valid !== 1'b0) begin errors++; $display("FAIL rmd_stale got=%b exp=0", I_valid); end
    d = 8'b0000_1000; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    checks++; if (I_valid !== 1'b1 || I !== 3'd3 || I_last !== 1'b1 || cnt !== 4'd1) begin
      errors++; $display("FAIL rmd_recap got v=%b I=%0d last=%b cnt=%0d exp v=1 I=3 last=1 cnt=1",
                         I_valid, I, I_last, cnt); end
    $display("recapture: I=%0d", I);
    step();
    checks++; if (I_valid !== 1'b0) begin errors++; $display("FAIL rmd_done got=%b exp=0", I_valid); end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; d = 8'h81; d_valid = 1'b1; I_ready = 1'b1;
    step();
    d = 8'h10;
    checks++; if (I !== 3'd7 || d_ready !== 1'b0) begin errors++; $display("FAIL b2b_first got I=%0d rdy=%b exp I=7 rdy=0", I, d_ready); end
    step();
    checks++; if (I !== 3'd0 || I_last !== 1'b1) begin errors++; $display("FAIL b2b_last got I=%0d last=%b exp I=0 last=1", I, I_last); end
    step();
    checks++; if (I_valid !== 1'b0 || d_ready !== 1'b1 || cnt !== 4'd2) begin
      errors++; $display("FAIL b2b_gap got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=2", I_valid, d_ready, cnt); end
    step();
    d_valid = 1'b0;
    checks++; if (I_valid !== 1'b1 || I !== 3'd4 || cnt !== 4'd1) begin
      errors++; $display("FAIL b2b_second got v=%b I=%0d cnt=%0d exp v=1 I=4 cnt=1", I_valid, I, cnt); end
    $display("back-to-back: I=%0d cnt=%0d", I, cnt);
    step();
    checks++; if (I_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got=%b exp=0", I_valid); end
  endtask

  initial begin
    test_reset();
    test_first_capture();
    test_single();
    test_multi();
    test_backpressure();
    test_zero();
    test_full_enable();
    test_reset_mid_drain();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
